// File: rtl/nsa_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder.
// NSA_OVF_EN (optional) adds the two's-complement overflow output.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nsa_state_e;

    // Slice counter width: clog2(WIDTH/4), never narrower than one bit
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width / NIBBLE_W);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// NSA_OVF_EN adds the ovf signal to the bundle.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef NSA_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef NSA_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef NSA_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/skip_adder_slice.sv
// Combinational 4-bit ripple adder whose carry-out bypasses the ripple
// chain when every bit propagates.
module skip_adder_slice
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic [NIBBLE_W-1:0] p_s;
    logic [NIBBLE_W:0]   c_s;

    // Ripple sum plus skip mux on the carry-out
    always_comb begin
        p_s    = a ^ b;
        c_s    = {(NIBBLE_W+1){1'b0}};
        s      = {NIBBLE_W{1'b0}};
        c_s[0] = ci;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]     = p_s[i] ^ c_s[i];
            c_s[i+1] = (a[i] & b[i]) | (p_s[i] & c_s[i]);
        end
        if (&p_s) begin
            co = ci;
        end else begin
            co = c_s[NIBBLE_W];
        end
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that processes one nibble per clock through a single
// carry-skip slice. NSA_OVF_EN adds a registered two's-complement overflow flag.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus
);

    localparam int N     = WIDTH / NIBBLE_W;
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

    nsa_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [WIDTH-1:0]    res_q, res_d;
    logic                carry_q, carry_d;
    logic                cout_q, cout_d;
    logic                valid_q, valid_d;
`ifdef NSA_OVF_EN
    logic                ovf_q, ovf_d;
`endif

    logic [NIBBLE_W-1:0] slice_sum_s;
    logic                slice_co_s;

    skip_adder_slice u_slice (
        .a  (a_q[NIBBLE_W-1:0]),
        .b  (b_q[NIBBLE_W-1:0]),
        .ci (carry_q),
        .s  (slice_sum_s),
        .co (slice_co_s)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef NSA_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
`ifdef NSA_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef NSA_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = RUN;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Operands drain from the bottom; results fill from the top
                a_d     = a_q >> NIBBLE_W;
                b_d     = b_q >> NIBBLE_W;
                res_d   = (res_q >> NIBBLE_W) |
                          (WIDTH'(slice_sum_s) << (WIDTH - NIBBLE_W));
                carry_d = slice_co_s;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_SLICE) begin
                    state_d = DONE;
                    cout_d  = slice_co_s;
`ifdef NSA_OVF_EN
                    // The operand MSBs sit in bit 3 once the top nibble reaches the slice
                    ovf_d   = (a_q[NIBBLE_W-1] == b_q[NIBBLE_W-1]) &&
                              (slice_sum_s[NIBBLE_W-1] != a_q[NIBBLE_W-1]);
`endif
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        valid_d = (state_d == DONE);
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = valid_q;
    assign bus.sum       = res_q;
    assign bus.cout      = cout_q;
`ifdef NSA_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule
